ac97_frame_tx: RTL and testbench

//  Codec-facing end of the audio path: serializes the mixer's SO2 (left) and SO1 (right) samples into AC97
//  256-bit output frames on SDATA_OUT/SYNC, and issues the sample-request strobe that paces the mixer.

---
 rtl/ac97_frame_tx.sv | 127 ++++++++++++
 tb/tb_ac97_frame_tx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ac97_frame_tx.sv
// AC97 output-frame serializer: SYNC/SDATA_OUT generation, sample strobe, one codec command per frame.
// Define AC97_TX_SIGNED_CONV_EN to invert the MSB of each latched PCM sample.
module ac97_frame_tx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PCM_WIDTH   = 20
) (
    input  logic                 I_CLK,
    input  logic                 I_RESET,
    input  logic                 I_BITCLK,
    input  logic [PCM_WIDTH-1:0] I_SO1,
    input  logic [PCM_WIDTH-1:0] I_SO2,
    output logic                 O_STROBE,
    output logic                 O_SYNC,
    output logic                 O_SDATA_OUT,
    input  logic                 I_CMD_VALID,
    input  logic                 I_CMD_RD,
    input  logic [6:0]           I_CMD_ADDR,
    input  logic [15:0]          I_CMD_DATA,
    output logic                 O_CMD_READY
);

    localparam int unsigned Last = SYNC_STAGES - 1;

    logic [SYNC_STAGES-1:0] bclk_sync_q;
    logic                   bclk_last_q;
    logic [7:0]             bit_cnt_q, bit_cnt_d;
    logic                   strobe_q, sync_q, sdata_q;
    logic                   sync_d, sdata_d;
    logic                   bit_evt, latch, cmd_accept;

    logic                   pend_vld_q, pend_rd_q;
    logic [6:0]             pend_addr_q;
    logic [15:0]            pend_data_q;

    logic                   frm_cmd_q, frm_rd_q;
    logic [6:0]             frm_addr_q;
    logic [15:0]            frm_data_q;
    logic [19:0]            frm_so1_q, frm_so2_q;

    logic [19:0]            so1_just, so2_just;
    logic [15:0]            tag;
    logic [255:0]           frame_vec;

    assign bit_evt     = bclk_sync_q[Last] & ~bclk_last_q;
    assign bit_cnt_d   = bit_cnt_q + 8'd1;
    assign latch       = bit_evt & (bit_cnt_q == 8'd254);
    assign cmd_accept  = I_CMD_VALID & ~pend_vld_q;
    assign O_CMD_READY = ~pend_vld_q;
    assign O_STROBE    = strobe_q;
    assign O_SYNC      = sync_q;
    assign O_SDATA_OUT = sdata_q;

    always_comb begin
        so1_just = 20'(I_SO1) << (20 - PCM_WIDTH);
        so2_just = 20'(I_SO2) << (20 - PCM_WIDTH);
`ifdef AC97_TX_SIGNED_CONV_EN
        so1_just[19] = ~so1_just[19];
        so2_just[19] = ~so2_just[19];
`endif
    end

    // Stream bit n lives at frame_vec[255-n]; slot 12 bit 0 (stream bit 255) is always zero.
    always_comb begin
        tag                = {1'b1, frm_cmd_q, frm_cmd_q & ~frm_rd_q, 2'b11, 11'h000};
        frame_vec          = '0;
        frame_vec[255:240] = tag;
        frame_vec[239:220] = {frm_rd_q, frm_addr_q, 12'h000};
        frame_vec[219:200] = {frm_data_q, 4'h0};
        frame_vec[199:180] = frm_so2_q;
        frame_vec[179:160] = frm_so1_q;
    end

    always_comb begin
        sync_d  = (bit_cnt_d == 8'd255) || (bit_cnt_d <= 8'd14);
        sdata_d = frame_vec[~bit_cnt_d];
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            bclk_sync_q <= '0;
            bclk_last_q <= 1'b0;
            bit_cnt_q   <= 8'd254;
            strobe_q    <= 1'b0;
            sync_q      <= 1'b0;
            sdata_q     <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_rd_q   <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            frm_cmd_q   <= 1'b0;
            frm_rd_q    <= 1'b0;
            frm_addr_q  <= '0;
            frm_data_q  <= '0;
            frm_so1_q   <= '0;
            frm_so2_q   <= '0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[Last-1:0], I_BITCLK};
            bclk_last_q <= bclk_sync_q[Last];
            strobe_q    <= latch;
            if (bit_evt) begin
                bit_cnt_q <= bit_cnt_d;
                sync_q    <= sync_d;
                sdata_q   <= sdata_d;
            end
            if (latch) begin
                frm_cmd_q   <= pend_vld_q;
                frm_rd_q    <= pend_rd_q;
                frm_addr_q  <= pend_addr_q;
                frm_data_q  <= pend_data_q;
                frm_so1_q   <= so1_just;
                frm_so2_q   <= so2_just;
                pend_vld_q  <= 1'b0;
                pend_rd_q   <= 1'b0;
                pend_addr_q <= '0;
                pend_data_q <= '0;
            end
            // Only possible when nothing is pending, so it never collides with the consume above.
            if (cmd_accept) begin
                pend_vld_q  <= 1'b1;
                pend_rd_q   <= I_CMD_RD;
                pend_addr_q <= I_CMD_ADDR;
                pend_data_q <= I_CMD_RD ? 16'h0000 : I_CMD_DATA;
            end
        end
    end

endmodule

// File: tb/tb_ac97_frame_tx.sv
// Bench for ac97_frame_tx: frame-level model checked at every bit, plus literal frame expectations.
module tb_ac97_frame_tx;

    logic        clk = 1'b0, rst = 1'b0, bitclk = 1'b0;
    logic [19:0] so1 = '0, so2 = '0;
    logic        strobe, sync, sdata, cmd_ready;
    logic        cmd_valid = 1'b0, cmd_rd = 1'b0;
    logic [6:0]  cmd_addr = '0;
    logic [15:0] cmd_data = '0;

    int checks = 0, errors = 0;
    int ph = 0, mcnt = 254, frames_done = 0, strobe_seen = 0, strobe_total = 0;
    bit bclk_en = 1'b0, cap_ok = 1'b0;
    logic [0:255] exp_fr = '0, rx = '0, last_rx = '0;
    logic [23:0]  pq[$];
    logic [23:0]  pe;

`ifdef AC97_TX_SIGNED_CONV_EN
    localparam logic [19:0] S3A = 20'h92345, S4A = 20'h2BCDE, S4G = 20'h80000;
`else
    localparam logic [19:0] S3A = 20'h12345, S4A = 20'hABCDE, S4G = 20'h00000;
`endif

    ac97_frame_tx dut (
        .I_CLK(clk), .I_RESET(rst), .I_BITCLK(bitclk), .I_SO1(so1), .I_SO2(so2),
        .O_STROBE(strobe), .O_SYNC(sync), .O_SDATA_OUT(sdata), .I_CMD_VALID(cmd_valid),
        .I_CMD_RD(cmd_rd), .I_CMD_ADDR(cmd_addr), .I_CMD_DATA(cmd_data), .O_CMD_READY(cmd_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] conv(input logic [19:0] s);
`ifdef AC97_TX_SIGNED_CONV_EN
        return s ^ 20'h80000;
`else
        return s;
`endif
    endfunction

    // Expected frame from the tag/slot rules; index = position in the serial stream.
    function automatic logic [0:255] build(input logic [19:0] s2, input logic [19:0] s1,
                                           input bit cmd, input bit rd, input logic [6:0] a,
                                           input logic [15:0] d);
        logic [0:255] f;
        logic [15:0]  t;
        f = '0;
        t = 16'h8000 | 16'h1800;
        if (cmd) t = t | 16'h4000;
        if (cmd && !rd) t = t | 16'h2000;
        f[0+:16] = t;
        if (cmd) f[16+:20] = {rd, a, 12'h000};
        if (cmd && !rd) f[36+:20] = {d, 4'h0};
        f[56+:20] = conv(s2);
        f[76+:20] = conv(s1);
        return f;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic chk_frame(input string nm, input logic [15:0] t, input logic [19:0] s1,
                             input logic [19:0] s2, input logic [19:0] s3, input logic [19:0] s4);
        chk({nm, " tag"}, 32'(last_rx[0+:16]), 32'(t));
        chk({nm, " slot1"}, 32'(last_rx[16+:20]), 32'(s1));
        chk({nm, " slot2"}, 32'(last_rx[36+:20]), 32'(s2));
        chk({nm, " slot3"}, 32'(last_rx[56+:20]), 32'(s3));
        chk({nm, " slot4"}, 32'(last_rx[76+:20]), 32'(s4));
        chk({nm, " slots5to12"}, 32'(|last_rx[96:255]), 32'd0);
    endtask

    task automatic wait_frames(input int n);
        int t;
        t = 0;
        while (frames_done < n && t < 6000) begin
            @(negedge clk);
            t++;
        end
        if (frames_done < n) begin
            checks++; errors++;
            $display("FAIL frame_timeout actual %0d required %0d", frames_done, n);
        end
    endtask

    task automatic wait_cnt(input int c, input int p);
        int t;
        t = 0;
        while (!(mcnt == c && ph == p) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            checks++; errors++;
            $display("FAIL cnt_timeout actual %0d required %0d", mcnt, c);
        end
    endtask

    task automatic wait_strobe(input string nm);
        int t;
        t = 0;
        while (strobe !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) begin
            checks++; errors++;
            $display("FAIL %s strobe_timeout actual 0 required 1", nm);
        end
    endtask

    // BIT_CLK: 8 I_CLK periods per bit; the model advances its bit count on each rise.
    always @(posedge clk) begin
        #1;
        if (bclk_en) begin
            ph = (ph + 1) % 8;
            if (ph == 4) begin
                bitclk = 1'b1;
                mcnt = (mcnt + 1) % 256;
                if (mcnt == 255) begin
                    if (pq.size() > 0) begin
                        pe = pq.pop_front();
                        exp_fr = build(so2, so1, 1'b1, pe[23], pe[22:16], pe[15:0]);
                    end else begin
                        exp_fr = build(so2, so1, 1'b0, 1'b0, 7'h00, 16'h0000);
                    end
                end
            end else if (ph == 0) begin
                bitclk = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && cmd_valid && cmd_ready) pq.push_back({cmd_rd, cmd_addr, cmd_data});
    end

    // Compare process: late in every bit period, check SYNC, SDATA and strobe count for that bit.
    always @(negedge clk) begin
        if (!rst && bclk_en) begin
            if (strobe === 1'b1) begin
                strobe_seen++;
                strobe_total++;
            end
            if (ph == 3) begin
                chk($sformatf("sync bit %0d", mcnt), 32'(sync), 32'(mcnt == 255 || mcnt <= 14));
                chk($sformatf("sdata bit %0d", mcnt), 32'(sdata), 32'(exp_fr[mcnt]));
                chk($sformatf("strobe bit %0d", mcnt), 32'(strobe_seen), 32'(mcnt == 255));
                strobe_seen = 0;
                rx[mcnt] = sdata;
                if (mcnt == 0) cap_ok = 1'b1;
                if (mcnt == 254 && cap_ok) begin
                    last_rx = rx;
                    frames_done++;
                end
            end
        end
    end

    initial begin
        so2 = 20'h12345;
        so1 = 20'hABCDE;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset sync", 32'(sync), 32'd0);
        chk("reset sdata", 32'(sdata), 32'd0);
        chk("reset strobe", 32'(strobe), 32'd0);
        chk("reset ready", 32'(cmd_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        bclk_en = 1'b1;

        wait_frames(1);
        chk_frame("nocmd", 16'h9800, 20'h0, 20'h0, S3A, S4A);

        wait_cnt(10, 0);
        chk("ready before write", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_addr = 7'h02; cmd_data = 16'h0808;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("ready after write accept", 32'(cmd_ready), 32'd0);
        wait_cnt(200, 0);
        chk("ready held mid frame", 32'(cmd_ready), 32'd0);
        wait_frames(2);
        chk("strobes after 512 rises", 32'(strobe_total), 32'd2);
        chk("ready before latch", 32'(cmd_ready), 32'd0);
        chk_frame("pre-write", 16'h9800, 20'h0, 20'h0, S3A, S4A);
        wait_cnt(0, 0);
        chk("ready after latch", 32'(cmd_ready), 32'd1);
        wait_frames(3);
        chk_frame("write", 16'hF800, 20'h02000, 20'h08080, S3A, S4A);

        wait_strobe("read");
        cmd_valid = 1'b1; cmd_rd = 1'b1; cmd_addr = 7'h26; cmd_data = 16'hFFFF;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("ready after read accept", 32'(cmd_ready), 32'd0);
        wait_frames(4);
        chk_frame("read-in-strobe", 16'h9800, 20'h0, 20'h0, S3A, S4A);
        wait_frames(5);
        chk_frame("read", 16'hD800, 20'hA6000, 20'h0, S3A, S4A);

        wait_cnt(100, 0);
        bclk_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midreset sync", 32'(sync), 32'd0);
        chk("midreset sdata", 32'(sdata), 32'd0);
        chk("midreset strobe", 32'(strobe), 32'd0);
        chk("midreset ready", 32'(cmd_ready), 32'd1);
        rst = 1'b0;
        mcnt = 254;
        cap_ok = 1'b0;
        strobe_seen = 0;
        exp_fr = '0;
        pq.delete();
        so1 = 20'h00000;
        @(negedge clk);
        bclk_en = 1'b1;
        wait_strobe("post-reset");
        chk("post-reset sync", 32'(sync), 32'd1);
        wait_frames(6);
        chk_frame("so1 zero", 16'h9800, 20'h0, 20'h0, S3A, S4G);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
